// File: rtl/sd_card_rst_pkg.sv
// Shared types and constants for the SD_CARD PLL reset sequencer.
package sd_card_rst_pkg;

    localparam int STATE_W    = 3;
    localparam int LOSS_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } seq_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sd_card_sync2.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module sd_card_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sd_card_pll_rst_seq.sv
// PLL reset sequencer on the 50 MHz reference clock: pulses pll_rst, qualifies locked,
// releases sys_rst then periph_rst. Macro SD_CARD_PLL_LOSS_CNT_EN adds the loss_cnt output.
module sd_card_pll_rst_seq
    import sd_card_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP    = 8,
    parameter int MAX_RETRIES    = 3
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               periph_rst,
    output logic               ready,
    output logic               fail,
    output logic [STATE_W-1:0] state
`ifdef SD_CARD_PLL_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0] loss_cnt
`endif
);

    localparam int MAX_COUNT = max4(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, RELEASE_GAP);
    localparam int TIMER_W   = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam int RETRY_W   = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TIMER_W-1:0] PLL_RST_LAST = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(RELEASE_GAP - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    logic lock_s;

    seq_state_t         state_d, state_q;
    logic [TIMER_W-1:0] timer_d, timer_q;
    logic [RETRY_W-1:0] retry_d, retry_q;
    logic pll_rst_d, pll_rst_q;
    logic sys_rst_d, sys_rst_q;
    logic periph_rst_d, periph_rst_q;
    logic ready_d, ready_q;
    logic fail_d, fail_q;

    sd_card_sync2 u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            PLL_RST: begin
                if (timer_q == PLL_RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle takes priority over a retry.
                if (lock_s) begin
                    state_d = STABLE;
                end else if (timer_q == LOCK_LAST) begin
                    retry_d = retry_q + 1'b1;
                    state_d = (retry_d == RETRY_LIMIT) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                if (!lock_s)                     state_d = WAIT_LOCK;
                else if (timer_q == STABLE_LAST) state_d = RELEASE;
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end else if (timer_q == GAP_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end
            end
            FAIL:    state_d = FAIL;
            default: state_d = PLL_RST;
        endcase

        timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;

        // Outputs follow the current state one cycle later, so all resets move together.
        pll_rst_d    = (state_q == PLL_RST);
        sys_rst_d    = !((state_q == RELEASE) || (state_q == RUN));
        periph_rst_d = (state_q != RUN);
        ready_d      = (state_q == RUN);
        fail_d       = fail_q || (state_q == FAIL);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= PLL_RST;
            timer_q      <= '0;
            retry_q      <= '0;
            pll_rst_q    <= 1'b1;
            sys_rst_q    <= 1'b1;
            periph_rst_q <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            pll_rst_q    <= pll_rst_d;
            sys_rst_q    <= sys_rst_d;
            periph_rst_q <= periph_rst_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign sys_rst    = sys_rst_q;
    assign periph_rst = periph_rst_q;
    assign ready      = ready_q;
    assign fail       = fail_q;
    assign state      = state_q;

`ifdef SD_CARD_PLL_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_d, loss_cnt_q;
    logic                  loss_evt;

    always_comb begin
        loss_evt   = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;
        loss_cnt_d = loss_cnt_q;
        if (loss_evt && (loss_cnt_q != '1)) loss_cnt_d = loss_cnt_q + 1'b1;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) loss_cnt_q <= '0;
        else     loss_cnt_q <= loss_cnt_d;
    end

    assign loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_sd_card_pll_rst_seq.sv
// Bench for sd_card_pll_rst_seq: randomized locked waveforms checked against a window-based timing model.
module tb_sd_card_pll_rst_seq;

  localparam int P_RST    = 4;
  localparam int P_TO     = 20;
  localparam int P_STB    = 8;
  localparam int P_GAP    = 3;
  localparam int P_RETRY  = 2;
  localparam int SYNC_LAT = 2;
  localparam int W0       = P_RST;
  localparam int MAXC     = 256;
  // PLL_RST entry to fail output: pulses + all lock windows + output register.
  localparam int FAIL_LAT = P_RETRY * (P_RST + P_TO) + 1;

  localparam int S_PLL = 0, S_SYS = 1, S_PER = 2, S_RDY = 3, S_FAIL = 4;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  logic locked = 1'b0;
  logic pll_rst, sys_rst, periph_rst, ready, fail;
  logic [2:0] state;
`ifdef SD_CARD_PLL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  always #10 refclk = ~refclk;

  sd_card_pll_rst_seq #(
    .PLL_RST_CYCLES (P_RST),
    .LOCK_TIMEOUT   (P_TO),
    .STABLE_CYCLES  (P_STB),
    .RELEASE_GAP    (P_GAP),
    .MAX_RETRIES    (P_RETRY)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .periph_rst (periph_rst),
    .ready      (ready),
    .fail       (fail),
    .state      (state)
`ifdef SD_CARD_PLL_LOSS_CNT_EN
    ,
    .loss_cnt   (loss_cnt)
`endif
  );

  int cyc;
  int n_checks;
  int n_pass;
  bit lk_arr [MAXC];
  bit tr_pll [MAXC];
  bit tr_sys [MAXC];
  bit tr_per [MAXC];
  bit tr_rdy [MAXC];
  bit tr_fail[MAXC];

  // ---------------- reference model ----------------
  // Lock windows open after each pll_rst attempt; lock_s is locked delayed by SYNC_LAT.
  function automatic int win_start(input int k);
    return P_RST + k * (P_TO + P_RST);
  endfunction

  function automatic int model_sys_fall(input int l_rise);
    int vis;
    vis = l_rise + SYNC_LAT;
    for (int k = 0; k < P_RETRY; k++) begin
      if (vis <= win_start(k) + P_TO - 1)
        return ((vis > win_start(k)) ? vis : win_start(k)) + 1 + P_STB + 1;
    end
    return -1;
  endfunction

  function automatic int model_retries(input int l_rise);
    int vis;
    vis = l_rise + SYNC_LAT;
    for (int k = 0; k < P_RETRY; k++)
      if (vis <= win_start(k) + P_TO - 1) return k;
    return P_RETRY - 1;
  endfunction

  // ---------------- trace helpers ----------------
  function automatic bit tr_bit(input int sel, input int c);
    case (sel)
      S_PLL:   return tr_pll[c];
      S_SYS:   return tr_sys[c];
      S_PER:   return tr_per[c];
      S_RDY:   return tr_rdy[c];
      default: return tr_fail[c];
    endcase
  endfunction

  function automatic int find_first(input int sel, input bit val, input int from);
    for (int c = from; c <= cyc && c < MAXC; c++)
      if (tr_bit(sel, c) == val) return c;
    return -1;
  endfunction

  function automatic int count_rises(input int sel);
    int n;
    n = 0;
    for (int c = 1; c <= cyc && c < MAXC; c++)
      if (tr_bit(sel, c) && !tr_bit(sel, c - 1)) n++;
    return n;
  endfunction

  function automatic int count_order_viol();
    int n;
    n = 0;
    for (int c = 0; c <= cyc && c < MAXC; c++) begin
      if (tr_pll[c] && (!tr_sys[c] || !tr_per[c])) n++;
      if (!tr_per[c] && tr_sys[c]) n++;
    end
    return n;
  endfunction

  // ---------------- drivers ----------------
  task automatic record();
    if (cyc < MAXC) begin
      tr_pll[cyc]  = pll_rst;
      tr_sys[cyc]  = sys_rst;
      tr_per[cyc]  = periph_rst;
      tr_rdy[cyc]  = ready;
      tr_fail[cyc] = fail;
    end
  endtask

  task automatic set_lock(input int from, input int to, input bit v);
    for (int c = from; c <= to && c < MAXC; c++) lk_arr[c] = v;
  endtask

  task automatic release_reset();
    rst    = 1'b1;
    locked = 1'b0;
    repeat (2) @(negedge refclk);
    rst = 1'b0;
    cyc = 0;
    record();
    locked = lk_arr[0];
  endtask

  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
    cyc++;
    record();
    if (cyc < MAXC) locked = lk_arr[cyc];
  endtask

  task automatic run_to(input int n);
    int lim;
    lim = (n < MAXC) ? n : MAXC - 1;
    while (cyc < lim) step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    locked = 1'b1;
    repeat (3) @(negedge refclk);
    #1;
    n_checks++; if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); else n_pass++;
    n_checks++; if (sys_rst !== 1'b1) $display("FAIL reset_sys_rst: got %b expected 1", sys_rst); else n_pass++;
    n_checks++; if (periph_rst !== 1'b1) $display("FAIL reset_periph_rst: got %b expected 1", periph_rst); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else n_pass++;
    n_checks++; if (fail !== 1'b0) $display("FAIL reset_fail: got %b expected 0", fail); else n_pass++;
    n_checks++; if (state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
`ifdef SD_CARD_PLL_LOSS_CNT_EN
    n_checks++; if (loss_cnt !== 8'd0) $display("FAIL reset_loss_cnt: got %0d expected 0", loss_cnt); else n_pass++;
`endif
  endtask

  task automatic test_clean();
    int d, l, e, got;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 5 : (i == 1) ? P_TO - SYNC_LAT - 1 : int'($urandom_range(0, P_TO - SYNC_LAT - 1));
      l = W0 + d;
      e = model_sys_fall(l);
      set_lock(0, MAXC - 1, 1'b0);
      set_lock(l, MAXC - 1, 1'b1);
      release_reset();
      run_to(e + P_GAP + 4);
      got = find_first(S_PLL, 1'b0, 0);
      n_checks++; if (got !== P_RST + 1) $display("FAIL clean_pll_fall d=%0d: got %0d expected %0d", d, got, P_RST + 1); else n_pass++;
      got = count_rises(S_PLL);
      n_checks++; if (got !== 0) $display("FAIL clean_extra_pulses d=%0d: got %0d expected 0", d, got); else n_pass++;
      got = find_first(S_SYS, 1'b0, 0);
      n_checks++; if (got !== e) $display("FAIL clean_sys_fall d=%0d: got %0d expected %0d", d, got, e); else n_pass++;
      got = find_first(S_PER, 1'b0, 0);
      n_checks++; if (got !== e + P_GAP) $display("FAIL clean_periph_fall d=%0d: got %0d expected %0d", d, got, e + P_GAP); else n_pass++;
      got = find_first(S_RDY, 1'b1, 0);
      n_checks++; if (got !== e + P_GAP) $display("FAIL clean_ready_rise d=%0d: got %0d expected %0d", d, got, e + P_GAP); else n_pass++;
      got = count_order_viol();
      n_checks++; if (got !== 0) $display("FAIL clean_order d=%0d: got %0d violations expected 0", d, got); else n_pass++;
`ifdef SD_CARD_PLL_LOSS_CNT_EN
      n_checks++; if (loss_cnt !== 8'd0) $display("FAIL clean_loss_cnt: got %0d expected 0", loss_cnt); else n_pass++;
`endif
    end
  endtask

  task automatic test_timeout_retry();
    int d, l, e, got, r0, f0, rise;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? P_TO : (i == 1) ? P_TO - SYNC_LAT : int'($urandom_range(P_TO - SYNC_LAT, 2 * P_TO));
      l = W0 + d;
      e = model_sys_fall(l);
      set_lock(0, MAXC - 1, 1'b0);
      set_lock(l, MAXC - 1, 1'b1);
      release_reset();
      run_to(e + P_GAP + 4);
      got = count_rises(S_PLL);
      n_checks++; if (got !== model_retries(l)) $display("FAIL retry_pulses d=%0d: got %0d expected %0d", d, got, model_retries(l)); else n_pass++;
      f0 = find_first(S_PLL, 1'b0, 0);
      rise = find_first(S_PLL, 1'b1, f0);
      r0 = win_start(1) - P_RST + 1;
      n_checks++; if (rise !== r0) $display("FAIL retry_pulse_rise d=%0d: got %0d expected %0d", d, rise, r0); else n_pass++;
      got = find_first(S_PLL, 1'b0, rise) - rise;
      n_checks++; if (got !== P_RST) $display("FAIL retry_pulse_len d=%0d: got %0d expected %0d", d, got, P_RST); else n_pass++;
      got = find_first(S_SYS, 1'b0, 0);
      n_checks++; if (got !== e) $display("FAIL retry_sys_fall d=%0d: got %0d expected %0d", d, got, e); else n_pass++;
      got = find_first(S_PER, 1'b0, 0);
      n_checks++; if (got !== e + P_GAP) $display("FAIL retry_periph_fall d=%0d: got %0d expected %0d", d, got, e + P_GAP); else n_pass++;
      got = count_order_viol();
      n_checks++; if (got !== 0) $display("FAIL retry_order d=%0d: got %0d violations expected 0", d, got); else n_pass++;
    end
  endtask

  task automatic test_fail();
    int got;
    set_lock(0, MAXC - 1, 1'b0);
    release_reset();
    run_to(FAIL_LAT + 10);
    got = count_rises(S_PLL);
    n_checks++; if (got !== P_RETRY - 1) $display("FAIL fail_extra_pulses: got %0d expected %0d", got, P_RETRY - 1); else n_pass++;
    got = find_first(S_FAIL, 1'b1, 0);
    n_checks++; if (got !== FAIL_LAT) $display("FAIL fail_rise: got %0d expected %0d", got, FAIL_LAT); else n_pass++;
    got = find_first(S_SYS, 1'b0, 0);
    n_checks++; if (got !== -1) $display("FAIL fail_sys_released: got %0d expected -1", got); else n_pass++;
    got = find_first(S_PER, 1'b0, 0);
    n_checks++; if (got !== -1) $display("FAIL fail_periph_released: got %0d expected -1", got); else n_pass++;
    n_checks++; if (pll_rst !== 1'b0) $display("FAIL fail_pll_rst: got %b expected 0", pll_rst); else n_pass++;
    n_checks++; if (state !== 3'd5) $display("FAIL fail_state: got %0d expected 5", state); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (fail !== 1'b0) $display("FAIL fail_cleared_by_rst: got %b expected 0", fail); else n_pass++;
    n_checks++; if (state !== 3'd0) $display("FAIL fail_rst_state: got %0d expected 0", state); else n_pass++;
  endtask

  task automatic test_glitch();
    int l, k, e, got;
    for (int i = 0; i < 4; i++) begin
      k = (i == 0) ? 5 : int'($urandom_range(0, P_STB - 1));
      l = W0 + int'($urandom_range(0, 10));
      // lock_s returns to 1 one cycle after it dropped; the stable count restarts from there.
      e = (l + 1 + k + 1 + SYNC_LAT) + 1 + P_STB + 1;
      set_lock(0, MAXC - 1, 1'b0);
      set_lock(l, MAXC - 1, 1'b1);
      lk_arr[l + 1 + k] = 1'b0;
      release_reset();
      run_to(e + P_GAP + 4);
      got = count_rises(S_PLL);
      n_checks++; if (got !== 0) $display("FAIL glitch_pll_pulse k=%0d: got %0d expected 0", k, got); else n_pass++;
      got = find_first(S_SYS, 1'b0, 0);
      n_checks++; if (got !== e) $display("FAIL glitch_sys_fall k=%0d: got %0d expected %0d", k, got, e); else n_pass++;
      got = find_first(S_PER, 1'b0, 0);
      n_checks++; if (got !== e + P_GAP) $display("FAIL glitch_periph_fall k=%0d: got %0d expected %0d", k, got, e + P_GAP); else n_pass++;
    end
  endtask

  task automatic test_run_loss();
    int l, e, dd, got;
    l  = W0 + int'($urandom_range(0, 10));
    e  = model_sys_fall(l);
    dd = e + P_GAP + int'($urandom_range(2, 10));
    set_lock(0, MAXC - 1, 1'b0);
    set_lock(l, dd - 1, 1'b1);
    release_reset();
    run_to(dd + SYNC_LAT + 1);
    n_checks++; if (ready !== 1'b1) $display("FAIL loss_ready_before: got %b expected 1", ready); else n_pass++;
    step();
    n_checks++; if (ready !== 1'b0) $display("FAIL loss_ready: got %b expected 0", ready); else n_pass++;
    n_checks++; if (sys_rst !== 1'b1) $display("FAIL loss_sys_rst: got %b expected 1", sys_rst); else n_pass++;
    n_checks++; if (periph_rst !== 1'b1) $display("FAIL loss_periph_rst: got %b expected 1", periph_rst); else n_pass++;
    n_checks++; if (pll_rst !== 1'b1) $display("FAIL loss_pll_rst: got %b expected 1", pll_rst); else n_pass++;
`ifdef SD_CARD_PLL_LOSS_CNT_EN
    run_to(dd + 8);
    n_checks++; if (loss_cnt !== 8'd1) $display("FAIL loss_cnt: got %0d expected 1", loss_cnt); else n_pass++;
`endif
    // With locked held low the retry budget must start afresh after the loss.
    run_to(dd + SYNC_LAT + 1 + FAIL_LAT + 6);
    got = find_first(S_FAIL, 1'b1, 0);
    n_checks++; if (got !== dd + SYNC_LAT + 1 + FAIL_LAT) $display("FAIL loss_retry_cleared: got %0d expected %0d", got, dd + SYNC_LAT + 1 + FAIL_LAT); else n_pass++;
  endtask

  task automatic test_async_rst_release();
    int l, e;
    l = W0 + int'($urandom_range(0, 10));
    e = model_sys_fall(l);
    set_lock(0, MAXC - 1, 1'b0);
    set_lock(l, MAXC - 1, 1'b1);
    release_reset();
    run_to(e);
    n_checks++; if (state !== 3'd3) $display("FAIL async_pre_state: got %0d expected 3", state); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (pll_rst !== 1'b1) $display("FAIL async_pll_rst: got %b expected 1", pll_rst); else n_pass++;
    n_checks++; if (sys_rst !== 1'b1) $display("FAIL async_sys_rst: got %b expected 1", sys_rst); else n_pass++;
    n_checks++; if (periph_rst !== 1'b1) $display("FAIL async_periph_rst: got %b expected 1", periph_rst); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL async_ready: got %b expected 0", ready); else n_pass++;
    n_checks++; if (state !== 3'd0) $display("FAIL async_state: got %0d expected 0", state); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    test_reset();
    test_clean();
    test_timeout_retry();
    test_fail();
    test_glitch();
    test_run_loss();
    test_async_rst_release();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
